// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
//   req/lock/wdata : per-requester write request, lock request and packed data
//   gnt            : one-hot-or-zero grant (combinational)
//   q/q_valid      : shared register contents and one-cycle write strobe
//   owner/locked   : last writer index and locked-burst indicator
interface shared_reg_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [IW-1:0]  owner;
  logic           locked;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_valid, owner, locked
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_valid, owner, locked
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sequencing writes from N requesters into one shared
// W-bit register, with bounded locked bursts of up to MAX_LOCK writes.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of shared_reg_arbiter_if (req/lock/wdata in,
//         gnt/q/q_valid/owner/locked out)
module shared_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [W-1:0]  q_r, q_n, sel;
  logic          q_valid_r, q_valid_n;
  logic [IW-1:0] owner_r, owner_n;
  logic [IW-1:0] gidx;
  logic          found;
  logic [N-1:0]  gnt_c;

  // Next index modulo N.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  endfunction

  // Grant selection and next-state logic.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    q_n       = q_r;
    q_valid_n = 1'b0;
    owner_n   = owner_r;
    gnt_c     = '0;
    gidx      = '0;
    found     = 1'b0;
    sel       = '0;
    cnt_inc   = cnt + CW'(1);

    // Locked owner keeps the register; otherwise round-robin from ptr.
    if (state == LOCKED && bus.req[owner_r]) begin
      found = 1'b1;
      gidx  = owner_r;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        int j;
        j = int'(ptr) + k;
        if (j >= int'(N)) j = j - int'(N);
        if (!found && bus.req[IW'(j)]) begin
          found = 1'b1;
          gidx  = IW'(j);
        end
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if (found && gidx == IW'(i)) begin
        gnt_c[i] = 1'b1;
        sel      = bus.wdata[i*W +: W];
      end
    end

    if (found) begin
      q_n       = sel;
      q_valid_n = 1'b1;
      owner_n   = gidx;
    end

    case (state)
      IDLE: begin
        if (found) begin
          if (bus.lock[gidx]) begin
            // ptr stays put so a fallback search resumes where it was.
            state_n = LOCKED;
            cnt_n   = CW'(1);
          end else begin
            ptr_n = wrap_inc(gidx);
          end
        end
      end
      LOCKED: begin
        if (bus.req[owner_r]) begin
          if (!bus.lock[owner_r] || cnt_inc == CW'(MAX_LOCK)) begin
            state_n = IDLE;
            ptr_n   = wrap_inc(owner_r);
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          // Owner dropped its request: same-cycle fallback, lock released.
          state_n = IDLE;
          cnt_n   = '0;
          ptr_n   = found ? wrap_inc(gidx) : wrap_inc(owner_r);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and shared register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      q_r       <= q_n;
      q_valid_r <= q_valid_n;
      owner_r   <= owner_n;
    end
  end

  // Grant is forced low while reset is asserted.
  assign bus.gnt     = rst ? gnt_c : '0;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
  assign bus.locked  = (state == LOCKED);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized self-checking bench for shared_reg_arbiter against a
// behavioural model of the arbitration rules, plus directed scenarios.
module tb_shared_reg_arbiter;
  localparam int unsigned N        = 4;
  localparam int unsigned W        = 8;
  localparam int unsigned MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

  shared_reg_arbiter #(.N(N), .W(W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int       m_ptr, m_owner, m_cnt;
  bit       m_locked, m_qv;
  logic [W-1:0] m_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_locked = 0; m_qv = 0; m_q = '0;
  endtask

  // Index granted under the current inputs, or -1.
  function automatic int exp_grant();
    if (m_locked && bus.req[m_owner]) return m_owner;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (bus.req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Apply one rising edge to the model.
  task automatic model_edge();
    int g;
    g = exp_grant();
    if (g < 0) begin
      m_qv = 0;
      if (m_locked) begin
        m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % int'(N);
      end
    end else begin
      m_q  = bus.wdata[g*W +: W];
      m_qv = 1;
      if (m_locked && g == m_owner) begin
        m_cnt++;
        if (!bus.lock[g] || m_cnt == int'(MAX_LOCK)) begin
          m_locked = 0; m_cnt = 0; m_ptr = (g + 1) % int'(N);
        end
      end else if (m_locked) begin
        m_locked = 0; m_cnt = 0; m_ptr = (g + 1) % int'(N);
      end else if (bus.lock[g]) begin
        m_locked = 1; m_cnt = 1;
      end else begin
        m_ptr = (g + 1) % int'(N);
      end
      m_owner = g;
    end
  endtask

  task automatic check_all();
    check("gnt",     32'(bus.gnt),     32'(onehot(exp_grant())));
    check("q",       32'(bus.q),       32'(m_q));
    check("q_valid", 32'(bus.q_valid), 32'(m_qv));
    check("owner",   32'(bus.owner),   32'(m_owner));
    check("locked",  32'(bus.locked),  32'(m_locked));
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // Drive inputs on the falling edge, compare, then advance the model.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N-1:0] l);
    @(negedge clk);
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = rand_data();
    #2;
    check_all();
    model_edge();
  endtask

  // Asynchronous reset pulse between edges; request-free release edge.
  task automatic reset_pulse();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_locked",  32'(bus.locked),  32'd0);
    check("rst_q",       32'(bus.q),       32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_owner",   32'(bus.owner),   32'd0);
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    model_reset();
    @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    bus.req   = 4'b1111;
    bus.lock  = '0;
    bus.wdata = rand_data();

    // Held in reset with all requests high.
    repeat (2) @(negedge clk);
    #2;
    check("hold_gnt",     32'(bus.gnt),     32'd0);
    check("hold_q",       32'(bus.q),       32'd0);
    check("hold_q_valid", 32'(bus.q_valid), 32'd0);
    check("hold_owner",   32'(bus.owner),   32'd0);
    check("hold_locked",  32'(bus.locked),  32'd0);

    // Release: grant 0 in the same cycle, then fair rotation.
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rel_gnt", 32'(bus.gnt), 32'b0001);
    check_all();
    model_edge();
    for (int k = 1; k < 8; k++) begin
      do_cycle(4'b1111, 4'b0000);
      check("fair_gnt", 32'(bus.gnt), 32'(onehot(k % 4)));
    end

    // Sparse round-robin, then idle.
    do_cycle(4'b1010, 4'b0000);
    check("sparse_gnt0", 32'(bus.gnt), 32'b0010);
    do_cycle(4'b1010, 4'b0000);
    check("sparse_gnt1", 32'(bus.gnt), 32'b1000);
    do_cycle(4'b0000, 4'b0000);
    do_cycle(4'b0000, 4'b0000);
    check("idle_q_valid", 32'(bus.q_valid), 32'd0);

    // Lock with early drop by requester 2.
    do_cycle(4'b1111, 4'b0100);
    do_cycle(4'b1111, 4'b0100);
    do_cycle(4'b1111, 4'b0100);
    check("lk_gnt0", 32'(bus.gnt), 32'b0100);
    do_cycle(4'b1111, 4'b0100);
    check("lk_gnt1", 32'(bus.gnt), 32'b0100);
    check("lk_locked", 32'(bus.locked), 32'd1);
    do_cycle(4'b1111, 4'b0000);
    check("lk_gnt2", 32'(bus.gnt), 32'b0100);
    do_cycle(4'b1111, 4'b0000);
    check("lk_next", 32'(bus.gnt), 32'b1000);

    // Forced release after MAX_LOCK writes by requester 1.
    do_cycle(4'b1111, 4'b0010);
    for (int k = 0; k < int'(MAX_LOCK); k++) begin
      do_cycle(4'b1111, 4'b0010);
      check("force_gnt", 32'(bus.gnt), 32'b0010);
    end
    do_cycle(4'b1111, 4'b0010);
    check("force_next", 32'(bus.gnt), 32'b0100);
    check("force_unlocked", 32'(bus.locked), 32'd0);

    // Owner 0 locks, then drops its request.
    do_cycle(4'b1111, 4'b0001);
    do_cycle(4'b1111, 4'b0001);
    check("drop_lock_gnt", 32'(bus.gnt), 32'b0001);
    do_cycle(4'b1000, 4'b0001);
    check("drop_gnt", 32'(bus.gnt), 32'b1000);
    do_cycle(4'b0000, 4'b0000);
    check("drop_unlocked", 32'(bus.locked), 32'd0);

    // Reset in the middle of a locked burst.
    do_cycle(4'b0001, 4'b0001);
    do_cycle(4'b0001, 4'b0001);
    check("mid_locked", 32'(bus.locked), 32'd1);
    reset_pulse();
    do_cycle(4'b1111, 4'b0000);
    check("post_rst_gnt", 32'(bus.gnt), 32'b0001);

    // Randomized traffic with frequent lock requests and rare resets.
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] r, l;
      r = N'($urandom);
      l = ($urandom_range(0, 3) != 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 99) == 0) reset_pulse();
      do_cycle(r, l);
    end

    @(negedge clk);
    #2;
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter sharing one W-bit enable-loaded register between N requesters.
- Each cycle at most one requester is granted, and its data is loaded into the shared flop on the next rising clk.
- A requester may lock the register for a bounded burst of consecutive writes.
- Sits in front of an enable/async-reset storage flop bank, acting as its write-enable sequencer.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width of the shared register.
- MAX_LOCK, 4, maximum consecutive grants in one locked burst (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester write request; bit i belongs to requester i.
- lock  input  N  per-requester lock request; qualified only together with req[i].
- wdata  input  N*W  packed write data; requester i uses bits [i*W +: W].
- gnt  output  N  one-hot or zero grant; combinational, valid in the same cycle as req.
- q  output  W  shared register contents.
- q_valid  output  1  high for one cycle after each cycle in which a write occurred.
- owner  output  $clog2(N)  index of the last requester written into q.
- locked  output  1  high while the FSM is in LOCKED.

Behaviour:
- Reset is asynchronous on rst low: q=0, q_valid=0, owner=0, locked=0, priority pointer ptr=0, lock_cnt=0, state IDLE. gnt=0 while rst is low.
- State IDLE, gnt:
  - Grant goes to the first i with req[i]=1, searching i = ptr, ptr+1, ..., wrapping modulo N.
  - gnt=0 if no requests.
- State IDLE, on an edge with gnt[i]=1:
  - q<=wdata[i], q_valid<=1, owner<=i, ptr<=(i+1) mod N.
  - If lock[i]=1: go to LOCKED, lock_cnt<=1, ptr unchanged.
- State LOCKED (lock_owner = owner):
  - If req[owner]=1, gnt = one-hot(owner) and all other requesters are stalled.
  - If req[owner]=0, fall back to the IDLE round-robin rule in the same cycle (no dead cycle). State goes to IDLE, ptr<=(grantee+1) mod N, or (owner+1) mod N if nothing is granted.
- LOCKED, grant to owner:
  - Write as above, lock_cnt<=lock_cnt+1.
  - Return to IDLE with ptr<=(owner+1) mod N and lock_cnt<=0 if lock[owner]=0 (final write) or lock_cnt+1==MAX_LOCK (forced release).
  - Otherwise stay in LOCKED.
- Maximum locked burst is MAX_LOCK consecutive writes. After a forced release the owner may re-lock only when it wins round-robin again.
- Write latency: q and q_valid update on the first rising edge after gnt is asserted.
- q_valid=0 in any cycle following a cycle with gnt=0. q holds its value when no write occurs.
- lock[i] without req[i] is ignored.
- Changes to lock[i] while not granted have no effect.
- Async reset mid-burst immediately clears locked and all state. The first post-reset grant starts from ptr=0.
- gnt is never multi-hot, and gnt[i]=1 only if req[i]=1.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> gnt=0, q=0, q_valid=0, owner=0, locked=0. Release rst -> gnt=4'b0001 in the same cycle.
- Fairness: req=4'b1111, no lock, 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each q equals the granted wdata one edge later, and q_valid is high every cycle.
- Sparse round-robin: ptr=0, req=4'b1010 -> gnt=4'b0010. Next cycle, same req -> gnt=4'b1000. Then req=4'b0000 -> q_valid low after one cycle and q unchanged.
- Lock with early drop: requester 2 with req=4'b1111, lock[2]=1 for 2 cycles, then lock[2]=0 -> three writes by 2 (owner=2, locked high for 2 cycles), then grant to requester 3.
- Forced release: MAX_LOCK=4, requester 1 holds req and lock with req=4'b1111 -> exactly 4 writes by 1, locked drops, next grant=4'b0100.
- Owner drop and mid-lock reset: in LOCKED, owner 0 drops req while req[3]=1 -> gnt=4'b1000 in the same cycle, locked=0 next. Separately, rst=0 pulse mid-lock -> locked=0 and q=0 immediately, first grant afterwards from index 0.
